// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types and constants for the binary-to-BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  // Number of BCD digits produced and the largest value they can show.
  localparam int BCD_DIGITS = 4;
  localparam int BCD_MAX    = 9999;

  typedef logic [3:0] bcd_digit_t;

  // Converter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Double-dabble correction for one BCD nibble: adds 3 when the
//                nibble is 5 or more, so the following left shift carries
//                correctly into the next decimal digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t nib_in,
  output bcd_digit_t nib_out
);

  // Plain 4-bit add; a valid BCD nibble (0..9) never carries out after +3.
  always_comb begin
    nib_out = nib_in;
    if (nib_in >= 4'd5) begin
      nib_out = nib_in + 4'd3;
    end
  end

endmodule : bcd_add3
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential double-dabble converter. One shift/add-3 step per
//                clock turns an unsigned WIDTH-bit value into four BCD digits.
//                Inputs above MAX_VALUE saturate and raise overflow. Digits
//                are registered and only updated once a conversion completes.
//                WIDTH is expected in the range 14..16.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH     = 14,
  parameter int MAX_VALUE = BCD_MAX
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             ready,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       digit_0,
  output logic [3:0]       digit_1,
  output logic [3:0]       digit_2,
  output logic [3:0]       digit_3
);

  localparam int               c_bcd_w = BCD_DIGITS * 4;
  localparam logic [4:0]       c_iter  = 5'(WIDTH);
  localparam logic [WIDTH-1:0] c_max   = WIDTH'(MAX_VALUE);

  // Registered state
  state_t             state_q,    state_d;
  logic               ready_q,    ready_d;
  logic               done_q,     done_d;
  logic               overflow_q, overflow_d;
  logic [c_bcd_w-1:0] bcd_q,      bcd_d;
  logic [WIDTH-1:0]   op_q,       op_d;
  logic [4:0]         cnt_q,      cnt_d;
  logic [c_bcd_w-1:0] digits_q,   digits_d;

  // Combinational helpers
  logic [c_bcd_w-1:0] w_bcd_adj;
  logic [WIDTH-1:0]   w_sat;
  logic               w_ovf;
  logic               w_unused_msb;

  // Saturate the incoming operand at the accepting edge.
  assign w_ovf = (bin_in > c_max);
  assign w_sat = w_ovf ? c_max : bin_in;

  // Add-3 correction on every scratch nibble before the shift.
  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_in  (bcd_q[gi*4 +: 4]),
      .nib_out (w_bcd_adj[gi*4 +: 4])
    );
  end

  // The bit shifted out of the top nibble is always zero for in-range operands.
  assign w_unused_msb = w_bcd_adj[c_bcd_w-1];

  // Next-state and datapath decode for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    bcd_d      = bcd_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    digits_d   = digits_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d       = w_sat;
          overflow_d = w_ovf;
          bcd_d      = '0;
          cnt_d      = '0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == c_iter) begin
          // All iterations done: publish digits together with the done pulse.
          digits_d = bcd_q;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          bcd_d = {w_bcd_adj[c_bcd_w-2:0], op_q[WIDTH-1]};
          op_d  = {op_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // ready is registered so it carries no path from start.
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset discards any conversion in flight.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bcd_q      <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      bcd_q      <= bcd_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign digit_0  = digits_q[3:0];
  assign digit_1  = digits_q[7:4];
  assign digit_2  = digits_q[11:8];
  assign digit_3  = digits_q[15:12];

endmodule : bin_to_bcd_seq
`default_nettype wire
